// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encodings, flag bundle, op decode helpers.
// Latency: none (definitions only).
// Backpressure: not applicable.
package alu_pkg;

    // op encoding as driven by the decode/operand stage
    localparam logic [1:0] OP_ADDA = 2'b00;  // arithmetic (signed) add
    localparam logic [1:0] OP_SUBA = 2'b01;  // arithmetic (signed) subtract
    localparam logic [1:0] OP_ADDL = 2'b10;  // logical (unsigned) add
    localparam logic [1:0] OP_SUBL = 2'b11;  // logical (unsigned) subtract

    typedef struct packed {
        logic of;
        logic sf;
        logic zf;
    } flags_t;

    function automatic logic is_sub(input logic [1:0] op);
        return op[0];
    endfunction

    function automatic logic is_logical(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/addsub_stage.sv
// One CHUNK-bit slice of the split carry chain: adds a + b + cin and registers sum slice and carry out.
// Latency: 1 cycle.
// Backpressure: registers load only while en is high, otherwise hold.
//
// Ports: clk, rst_n (async active-low), en (pipe advance), a/b slices, cin,
//        sum (registered slice), cout (registered carry out of the slice).
module addsub_stage #(
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (en) begin
            sum  <= total[CHUNK-1:0];
            cout <= total[CHUNK];
        end
    end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit with OF/SF/ZF flags; carry chain cut into CHUNK-bit slices, one per stage.
// Latency: STAGES = WIDTH/CHUNK cycles from accept to out_valid, plus one per stall cycle.
// Backpressure: the whole pipe advances together when !out_valid | out_ready; in_ready mirrors that.
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready, op, a, b (input beat);
//        out_valid/out_ready, s, of, sf, zf (result beat).
// Optional feature macro ADDSUB_PIPE_SAT_EN: adds input sat; overflowing results clamp when sat=1.
module addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ADDSUB_PIPE_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             of,
    output logic             sf,
    output logic             zf
);

    localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
    localparam int STAGES     = (WIDTH / SAFE_CHUNK < 1) ? 1 : WIDTH / SAFE_CHUNK;
    localparam int LAST       = STAGES - 1;
    localparam bit BAD_CFG    = (CHUNK < 1) || ((WIDTH % SAFE_CHUNK) != 0);

    generate
        if (BAD_CFG) begin : g_bad_cfg
            $error("addsub_pipe: WIDTH must be a non-zero multiple of CHUNK and CHUNK >= 1");
        end
    endgenerate

    logic                              adv;
    logic                              sat_in;
    logic [WIDTH-1:0]                  b_eff;

    // Per-stage pipeline state. a_q/b_q are the operand skew registers (upper
    // slices still waiting for their stage), lo_q is the deskew register
    // holding result slices already produced by earlier stages.
    logic [STAGES-1:0]                 vld_q;
    logic [STAGES-1:0][1:0]            op_q;
    logic [STAGES-1:0]                 sat_q;
    logic [STAGES-1:0][WIDTH-1:0]      a_q;
    logic [STAGES-1:0][WIDTH-1:0]      b_q;
    logic [STAGES-1:0][WIDTH-1:0]      lo_q;

    // Slice adder inputs and registered outputs.
    logic [STAGES-1:0][CHUNK-1:0]      st_a;
    logic [STAGES-1:0][CHUNK-1:0]      st_b;
    logic [STAGES-1:0]                 st_cin;
    logic [STAGES-1:0][CHUNK-1:0]      sum_q;
    logic [STAGES-1:0]                 cout_q;

    // Final-stage result and flag logic.
    logic [WIDTH-1:0]                  s_raw;
    logic [WIDTH-1:0]                  s_fin;
    logic                              msb_cin;
    logic                              of_raw;
    flags_t                            flags;

`ifdef ADDSUB_PIPE_SAT_EN
    assign sat_in = sat;
`else
    assign sat_in = 1'b0;
`endif

    assign out_valid = vld_q[LAST];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    // Subtraction is a + ~b + 1; the +1 enters as carry-in of slice 0.
    assign b_eff = is_sub(op) ? ~b : b;

    always_comb begin
        st_a      = '0;
        st_b      = '0;
        st_cin    = '0;
        st_a[0]   = a[CHUNK-1:0];
        st_b[0]   = b_eff[CHUNK-1:0];
        st_cin[0] = is_sub(op);
        for (int k = 1; k < STAGES; k++) begin
            st_a[k]   = a_q[k-1][k*CHUNK +: CHUNK];
            st_b[k]   = b_q[k-1][k*CHUNK +: CHUNK];
            st_cin[k] = cout_q[k-1];
        end
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            addsub_stage #(
                .CHUNK (CHUNK)
            ) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (adv),
                .a     (st_a[k]),
                .b     (st_b[k]),
                .cin   (st_cin[k]),
                .sum   (sum_q[k]),
                .cout  (cout_q[k])
            );
        end
    endgenerate

    // Control, skew and deskew registers move in lockstep with the slice
    // adders. Data registers load on every advance, so bubbles carry stale
    // data that is never exposed (outputs are gated by out_valid).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            op_q  <= '0;
            sat_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            lo_q  <= '0;
        end else if (adv) begin
            vld_q[0] <= in_valid;
            op_q[0]  <= op;
            sat_q[0] <= sat_in;
            a_q[0]   <= a;
            b_q[0]   <= b_eff;
            lo_q[0]  <= '0;
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
                op_q[k]  <= op_q[k-1];
                sat_q[k] <= sat_q[k-1];
                a_q[k]   <= a_q[k-1];
                b_q[k]   <= b_q[k-1];
                lo_q[k]  <= lo_q[k-1] | (WIDTH'(sum_q[k-1]) << ((k-1) * CHUNK));
            end
        end
    end

    assign s_raw = lo_q[LAST] | (WIDTH'(sum_q[LAST]) << (LAST * CHUNK));

    // Carry into the MSB recovered from the MSB sum bit: sum = a ^ b ^ cin.
    assign msb_cin = a_q[LAST][WIDTH-1] ^ b_q[LAST][WIDTH-1] ^ s_raw[WIDTH-1];

    always_comb begin
        of_raw = 1'b0;
        s_fin  = s_raw;
        if (is_logical(op_q[LAST])) begin
            // unsigned: carry out for add, borrow (= no carry) for subtract
            of_raw = is_sub(op_q[LAST]) ? !cout_q[LAST] : cout_q[LAST];
        end else begin
            of_raw = msb_cin ^ cout_q[LAST];
        end
`ifdef ADDSUB_PIPE_SAT_EN
        if (sat_q[LAST] && of_raw) begin
            if (is_logical(op_q[LAST])) begin
                s_fin = is_sub(op_q[LAST]) ? '0 : '1;
            end else begin
                // A signed overflow flips the sign bit, so a negative-looking
                // wrapped result means the true result was positive.
                s_fin = s_raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                       : {1'b1, {(WIDTH-1){1'b0}}};
            end
        end
`endif
    end

    always_comb begin
        flags.of = out_valid && of_raw;
        flags.sf = out_valid && s_fin[WIDTH-1];
        flags.zf = out_valid && (s_fin == '0);
    end

    assign s  = out_valid ? s_fin : '0;
    assign of = flags.of;
    assign sf = flags.sf;
    assign zf = flags.zf;

    // Skew/deskew bits outside a stage's live window are intentionally unread.
    logic unused_pipe_bits;
    assign unused_pipe_bits = ^{a_q, b_q, lo_q, sat_q};

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=16, CHUNK=8, latency 2).
// Latency: checks accept-to-result latency of 2 cycles.
// Backpressure: exercises out_ready stalls with a scoreboard queue.
`timescale 1ns/1ps
module tb_addsub_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        sat;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        of;
    logic        sf;
    logic        zf;

    int total = 0;
    int bad   = 0;

    // expected {s, of, sf, zf}
    logic [18:0] exp_q[$];

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        sat;
        logic [18:0] exp;
    } vec_t;

    addsub_pipe #(
        .WIDTH (16),
        .CHUNK (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
`ifdef ADDSUB_PIPE_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .of        (of),
        .sf        (sf),
        .zf        (zf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model using 17-bit unsigned and signed arithmetic.
    function automatic logic [18:0] model(input logic [1:0] mop, input logic [15:0] ma,
                                          input logic [15:0] mb, input logic msat);
        logic [16:0]        u;
        logic signed [16:0] sv;
        logic [15:0]        r;
        logic               mof;
        if (mop[0]) begin
            u  = {1'b0, ma} - {1'b0, mb};
            sv = $signed({ma[15], ma}) - $signed({mb[15], mb});
        end else begin
            u  = {1'b0, ma} + {1'b0, mb};
            sv = $signed({ma[15], ma}) + $signed({mb[15], mb});
        end
        r   = u[15:0];
        mof = mop[1] ? u[16] : (sv[16] ^ sv[15]);
        if (msat && mof) begin
            case (mop)
                2'b10:   r = 16'hFFFF;
                2'b11:   r = 16'h0000;
                default: r = sv[16] ? 16'h8000 : 16'h7FFF;
            endcase
        end
        return {r, mof, r[15], (r == 16'h0000)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t, required finish before 200000", $time);
        $fatal(1);
    end

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 2'b00;
        a         = '0;
        b         = '0;
        sat       = 1'b0;
        #12;
        total++;
        if ({out_valid, s, of, sf, zf} !== 20'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h, required 0", {out_valid, s, of, sf, zf});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_flags();
        vec_t tbl[6] = '{
            '{2'b00, 16'h7FFF, 16'h0001, 1'b0, {16'h8000, 3'b110}},
            '{2'b10, 16'hFFFF, 16'h0001, 1'b0, {16'h0000, 3'b101}},
            '{2'b00, 16'hFFFF, 16'h0001, 1'b0, {16'h0000, 3'b001}},
            '{2'b11, 16'h0000, 16'h0001, 1'b0, {16'hFFFF, 3'b110}},
            '{2'b01, 16'h0000, 16'h0001, 1'b0, {16'hFFFF, 3'b010}},
            '{2'b01, 16'h8000, 16'h0001, 1'b0, {16'h7FFF, 3'b100}}
        };
        int lat;
        logic [18:0] e;
        foreach (tbl[i]) begin
            @(posedge clk); #1;
            in_valid = 1'b1; op = tbl[i].op; a = tbl[i].a; b = tbl[i].b; sat = tbl[i].sat;
            out_ready = 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) exp_q.push_back(tbl[i].exp);
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 1;
            @(negedge clk);
            while (out_valid !== 1'b1 && lat < 10) begin
                lat++;
                @(negedge clk);
            end
            total++;
            if (lat != 2) begin
                bad++;
                $display("FAIL flags_latency[%0d]: got %0d, required 2", i, lat);
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h7FFFF;
            total++;
            if ({s, of, sf, zf} !== e) begin
                bad++;
                $display("FAIL flags_result[%0d]: got s=%h of/sf/zf=%b, required s=%h of/sf/zf=%b",
                         i, s, {of, sf, zf}, e[18:3], e[2:0]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  pat = 8'b1001_1011;
        logic [18:0] held;
        logic [18:0] e;
        logic        have_held = 1'b0;
        int          sent = 0;
        int          recv = 0;
        int          extra = 0;
        logic [1:0]  n_op = 2'($urandom_range(0, 3));
        logic [15:0] n_a  = 16'($urandom);
        logic [15:0] n_b  = 16'($urandom);
        sat = 1'b0;
        for (int cyc = 0; cyc < 80 && recv < 8; cyc++) begin
            @(posedge clk); #1;
            in_valid  = (sent < 8);
            op = n_op; a = n_a; b = n_b;
            out_ready = pat[7 - (cyc % 8)];
            @(negedge clk);
            if (out_valid) begin
                if (have_held) begin
                    total++;
                    if ({s, of, sf, zf} !== held) begin
                        bad++;
                        $display("FAIL stall_hold: got %h, required %h", {s, of, sf, zf}, held);
                    end
                end
                if (out_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL b2b_extra: got result %h, required none", {s, of, sf, zf});
                    end else begin
                        e = exp_q.pop_front();
                        if ({s, of, sf, zf} !== e) begin
                            bad++;
                            $display("FAIL b2b_result[%0d]: got %h, required %h", recv, {s, of, sf, zf}, e);
                        end
                    end
                    recv++;
                    have_held = 1'b0;
                end else begin
                    held      = {s, of, sf, zf};
                    have_held = 1'b1;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(op, a, b, 1'b0));
                sent++;
                n_op = 2'($urandom_range(0, 3));
                n_a  = 16'($urandom);
                n_b  = 16'($urandom);
            end
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        total++;
        if (recv != 8 || sent != 8 || exp_q.size() != 0 || extra != 0) begin
            bad++;
            $display("FAIL b2b_count: got sent=%0d recv=%0d left=%0d extra=%0d, required 8 8 0 0",
                     sent, recv, exp_q.size(), extra);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int lat;
        logic [18:0] e;
        out_ready = 1'b1;
        sat = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; op = 2'b00; a = 16'h1234; b = 16'h1111;
        @(posedge clk); #1;
        op = 2'b01; a = 16'h5555; b = 16'h0005;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_valid: got %b, required 0", out_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL midreset_ghost: got %0d results, required 0", seen);
        end
        @(posedge clk); #1;
        in_valid = 1'b1; op = 2'b10; a = 16'h00F0; b = 16'h0F10;
        @(negedge clk);
        if (in_valid && in_ready) exp_q.push_back(model(op, a, b, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (out_valid !== 1'b1 && lat < 10) begin
            lat++;
            @(negedge clk);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h7FFFF;
        total++;
        if (lat != 2 || {s, of, sf, zf} !== e) begin
            bad++;
            $display("FAIL midreset_next: got lat=%0d val=%h, required lat=2 val=%h", lat, {s, of, sf, zf}, e);
        end
        @(posedge clk); #1;
    endtask

`ifdef ADDSUB_PIPE_SAT_EN
    task automatic test_sat();
        vec_t tbl[3] = '{
            '{2'b00, 16'h7FFF, 16'h7FFF, 1'b1, {16'h7FFF, 3'b100}},
            '{2'b11, 16'h0001, 16'h0002, 1'b1, {16'h0000, 3'b101}},
            '{2'b00, 16'h7FFF, 16'h7FFF, 1'b0, {16'hFFFE, 3'b110}}
        };
        int lat;
        logic [18:0] e;
        foreach (tbl[i]) begin
            @(posedge clk); #1;
            in_valid = 1'b1; op = tbl[i].op; a = tbl[i].a; b = tbl[i].b; sat = tbl[i].sat;
            out_ready = 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) exp_q.push_back(tbl[i].exp);
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 1;
            @(negedge clk);
            while (out_valid !== 1'b1 && lat < 10) begin
                lat++;
                @(negedge clk);
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h7FFFF;
            total++;
            if (lat != 2 || {s, of, sf, zf} !== e) begin
                bad++;
                $display("FAIL sat[%0d]: got lat=%0d s=%h of/sf/zf=%b, required lat=2 s=%h of/sf/zf=%b",
                         i, lat, s, {of, sf, zf}, e[18:3], e[2:0]);
            end
        end
        @(posedge clk); #1;
        sat = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_flags();
        test_back_to_back();
        test_reset_mid();
`ifdef ADDSUB_PIPE_SAT_EN
        test_sat();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined add/subtract unit; next-generation replacement for the 16-bit combinational adder in the COMET2 ALU.
- Splits the carry chain into CHUNK-bit slices, one slice per pipeline stage.
- Supports the COMET2 arithmetic and logical add/sub ops and produces OF/SF/ZF flags.
- Uses a valid/ready handshake with full backpressure; sits between the decode/operand stage and the writeback/flag register.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per stage. STAGES = WIDTH/CHUNK, which is also the latency in cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit accepts a beat this cycle.
- op  in  2  00 ADDA, 01 SUBA, 10 ADDL, 11 SUBL.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- s  out  WIDTH  result.
- of  out  1  overflow flag.
- sf  out  1  sign flag.
- zf  out  1  zero flag.

Behaviour:
- Reset: asynchronous; all stage valid bits = 0. out_valid, s, of, sf, zf = 0. in_ready = 1 once rst_n is high.
- Advance enable: adv = !out_valid | out_ready; the whole pipe moves together. in_ready = adv.
- A beat is accepted when in_valid & in_ready. Its result appears with out_valid=1 exactly STAGES cycles later if no stall occurs. Each stall cycle adds one cycle.
- Outputs hold stable while out_valid & !out_ready.
- Accept and complete in the same cycle is allowed; throughput is 1 beat/cycle.
- Subtraction: b is inverted and carry-in = 1 at stage 0.
- Stage k adds slice k using the registered carry from stage k-1. Upper operand slices travel through skew registers; lower result slices travel through deskew registers. Stage k registers slice k of s.
- Flags, computed in the final stage:
  - sf = s[WIDTH-1]; zf = (s == 0).
  - ADDA/SUBA: of = signed overflow, i.e. carry into MSB XOR carry out of MSB.
  - ADDL: of = carry out.
  - SUBL: of = borrow, i.e. NOT carry out.
- Wrap-around: the result is modulo 2^WIDTH; s is never wider than WIDTH.
- A bubble (stage valid = 0) moves through the pipe; its data registers may hold stale values and are not observable.
- Reset mid-operation: in-flight beats are discarded; no result for them is ever emitted.
- STAGES = 1 (CHUNK = WIDTH): single registered stage, latency 1.
- Elaboration error if WIDTH % CHUNK != 0 or CHUNK < 1.

Optional Feature:
- Macro: ADDSUB_PIPE_SAT_EN.
- With the macro:
  - Adds input port sat (1 bit), sampled with a and carried down the pipe.
  - When sat=1 and of=1, s clamps:
    - ADDA/SUBA: 0x7FFF.. if the true result was positive, 0x80.. if negative.
    - ADDL: all ones.
    - SUBL: zero.
  - of still reports 1. sf and zf are derived from the clamped s.
- Without the macro: port sat is absent; results always wrap.

Decomposition:
- Package alu_pkg holds:
  - the op encoding constants (OP_ADDA, OP_SUBA, OP_ADDL, OP_SUBL);
  - the flags struct {of, sf, zf};
  - an is_sub(op) function and an is_logical(op) function.
- One sub-module, addsub_stage: a CHUNK-bit slice adder with registered sum slice and carry out, instantiated STAGES times by a generate loop.

Test Plan (WIDTH=16, CHUNK=8, latency 2):
- ADDA 0x7FFF + 0x0001 -> s=0x8000, of=1, sf=1, zf=0, two cycles after accept.
- ADDL 0xFFFF + 0x0001 -> s=0x0000, of=1, sf=0, zf=1. ADDA with the same operands -> of=0.
- SUBL 0x0000 - 0x0001 -> s=0xFFFF, of=1, sf=1. SUBA with the same operands -> s=0xFFFF, of=0. SUBA 0x8000 - 0x0001 -> s=0x7FFF, of=1.
- Eight back-to-back beats with out_ready toggling in pattern 1,0,0,1,1,0,1,1 -> all eight results emitted in order, none lost or duplicated, outputs stable during stalls.
- Two beats in flight, then rst_n pulled low for one cycle mid-stage -> out_valid=0 immediately and no result emitted afterwards; the next beat returns a correct result with latency 2.
- With ADDSUB_PIPE_SAT_EN defined:
  - ADDA 0x7FFF + 0x7FFF, sat=1 -> s=0x7FFF, of=1, sf=0.
  - SUBL 0x0001 - 0x0002, sat=1 -> s=0x0000, of=1, zf=1.
  - ADDA 0x7FFF + 0x7FFF, sat=0 -> s=0xFFFE, of=1.
